uart_cmd_framer: RTL and testbench

- Sits directly downstream and upstream of the UART block on its byte-level side.
- Assembles pairs of received bytes, high byte first, into 16-bit commands for the command processor.
- Recovers from half-received frames with an inter-byte timeout.
- Sends one-byte responses from the processor back out through the UART transmitter, using its trmt/tx_done handshake.

---
 rtl/uart_cmd_pkg.sv | 7 +
 rtl/uart_cmd_framer_if.sv | 27 ++
 rtl/uart_resp_tx.sv | 43 ++++
 rtl/uart_cmd_framer.sv | 67 ++++++
 tb/tb_uart_cmd_framer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared widths and FSM state types for the UART command framer
package uart_cmd_pkg;
  localparam int BYTE_W = 8;
  localparam int CMD_W = 16;
  typedef enum logic {RX_IDLE, RX_WAIT_LO} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;
endpackage

// File: rtl/uart_cmd_framer_if.sv
// uart_cmd_framer_if: byte-side UART and command-processor signals of the framer
interface uart_cmd_framer_if;
  import uart_cmd_pkg::*;
  logic rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic clr_rx_rdy;
  logic tx_done;
  logic trmt;
  logic [BYTE_W-1:0] tx_data;
  logic [CMD_W-1:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic frame_err;
  logic cmd_ovr;
  logic send_resp;
  logic [BYTE_W-1:0] resp;
  logic resp_busy;
  logic resp_sent;
  modport slave (
    input rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp,
    output clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, frame_err, cmd_ovr, resp_busy, resp_sent
  );
  modport master (
    output rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp,
    input clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, frame_err, cmd_ovr, resp_busy, resp_sent
  );
endinterface

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: sends one response byte through the UART trmt/tx_done handshake
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_send_resp,
  input  logic [BYTE_W-1:0] i_resp,
  input  logic              i_tx_done,
  output logic              o_trmt,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic              o_resp_busy,
  output logic              o_resp_sent
);
  tx_state_t r_state, w_next;
  logic [BYTE_W-1:0] r_tx_data;
  logic r_first, r_busy, r_sent, w_done;
  // state, latched byte, busy flag and completion pulse; r_first masks the stale tx_done right after trmt
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= TX_IDLE;
      r_first <= 1'b0;
      r_tx_data <= '0;
      r_busy <= 1'b0;
      r_sent <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= r_state == TX_START;
      r_sent <= w_done;
      r_busy <= r_state == TX_IDLE ? i_send_resp : !w_done;
      if (r_state == TX_IDLE && i_send_resp) r_tx_data <= i_resp;
    end
  // next state, transmit strobe and end-of-byte detect
  always_comb begin
    w_done = r_state == TX_WAIT && !r_first && i_tx_done;
    o_trmt = r_state == TX_START;
    w_next = r_state == TX_IDLE ? (i_send_resp ? TX_START : TX_IDLE) :
             r_state == TX_START ? TX_WAIT : (w_done ? TX_IDLE : TX_WAIT);
  end
  assign o_tx_data = r_tx_data;
  assign o_resp_busy = r_busy;
  assign o_resp_sent = r_sent;
endmodule

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: pairs UART bytes into 16-bit commands and returns response bytes
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1024,
  parameter int TMR_W = 16
) (
  input logic clk,
  input logic rst,
  uart_cmd_framer_if.slave bus
);
  rx_state_t r_state, w_next;
  logic [BYTE_W-1:0] r_hi;
  logic [TMR_W-1:0] r_tmr;
  logic [CMD_W-1:0] r_cmd;
  logic r_cmd_rdy, r_frame_err, r_cmd_ovr;
  logic w_accept, w_timeout, w_complete;
  logic w_trmt, w_resp_busy, w_resp_sent;
  logic [BYTE_W-1:0] w_tx_data;
  // RX state register
  always_ff @(posedge clk) r_state <= rst ? RX_IDLE : w_next;
  // byte accept, timeout and completion decode; a low byte beats a same-cycle timeout
  always_comb begin
    w_accept = bus.rx_rdy;
    w_complete = r_state == RX_WAIT_LO && w_accept;
    w_timeout = r_state == RX_WAIT_LO && !w_accept && r_tmr == TMR_W'(TIMEOUT_CLKS - 1);
    w_next = r_state == RX_IDLE ? (w_accept ? RX_WAIT_LO : RX_IDLE) :
             (w_accept || w_timeout) ? RX_IDLE : RX_WAIT_LO;
  end
  // high byte, inter-byte timer, command register and status pulses
  always_ff @(posedge clk)
    if (rst) begin
      r_hi <= '0;
      r_tmr <= '0;
      r_cmd <= '0;
      r_cmd_rdy <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_ovr <= 1'b0;
    end else begin
      r_tmr <= r_state == RX_IDLE ? '0 : r_tmr + 1'b1;
      r_frame_err <= w_timeout;
      r_cmd_ovr <= w_complete && r_cmd_rdy;
      r_cmd_rdy <= w_complete || (r_cmd_rdy && !bus.clr_cmd_rdy);
      if (r_state == RX_IDLE && w_accept) r_hi <= bus.rx_data;
      if (w_complete) r_cmd <= {r_hi, bus.rx_data};
    end
  uart_resp_tx u_tx (
    .clk(clk),
    .rst(rst),
    .i_send_resp(bus.send_resp),
    .i_resp(bus.resp),
    .i_tx_done(bus.tx_done),
    .o_trmt(w_trmt),
    .o_tx_data(w_tx_data),
    .o_resp_busy(w_resp_busy),
    .o_resp_sent(w_resp_sent)
  );
  assign bus.clr_rx_rdy = w_accept;
  assign bus.cmd = r_cmd;
  assign bus.cmd_rdy = r_cmd_rdy;
  assign bus.frame_err = r_frame_err;
  assign bus.cmd_ovr = r_cmd_ovr;
  assign bus.trmt = w_trmt;
  assign bus.tx_data = w_tx_data;
  assign bus.resp_busy = w_resp_busy;
  assign bus.resp_sent = w_resp_sent;
endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed and random checks of the framer against a byte-stream model
module tb_uart_cmd_framer;
  localparam int T = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_cmd_framer_if u_if ();
  uart_cmd_framer #(.TIMEOUT_CLKS(T), .TMR_W(8)) dut (.clk(clk), .rst(rst), .bus(u_if));
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  int tm = 0;
  int n_clr = 0, n_ferr = 0, n_ovr = 0, n_trmt = 0, n_sent = 0;
  int e_clr = 0, e_ferr = 0, e_ovr = 0;
  logic [15:0] e_cmd = '0;
  logic e_rdy = 1'b0;
  bit have_hi = 0;
  logic [7:0] hi = '0;
  int t_hi = 0;
  int u_cnt = 0;
  logic [7:0] trmt_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit p;
    p = u_if.trmt;
    n_clr += int'(u_if.clr_rx_rdy);
    @(posedge clk);
    tm++;
    #1;
    if (p) begin
      u_if.tx_done = 1'b0;
      u_cnt = 170;
    end else if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) u_if.tx_done = 1'b1;
    end
    n_ferr += int'(u_if.frame_err);
    n_ovr += int'(u_if.cmd_ovr);
    n_trmt += int'(u_if.trmt);
    n_sent += int'(u_if.resp_sent);
    if (u_if.trmt) trmt_data = u_if.tx_data;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    if (have_hi && tm - t_hi >= T) begin
      have_hi = 0;
      e_ferr++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (have_hi && tm - t_hi > T) begin
      have_hi = 0;
      e_ferr++;
    end
    if (have_hi) begin
      e_ovr += int'(e_rdy);
      e_cmd = {hi, b};
      e_rdy = 1'b1;
      have_hi = 0;
    end else begin
      have_hi = 1;
      hi = b;
      t_hi = tm;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    u_if.rx_data = b;
    u_if.rx_rdy = 1'b1;
    u_if.clr_cmd_rdy = ack;
    e_clr++;
    tick();
    u_if.rx_rdy = 1'b0;
    u_if.clr_cmd_rdy = 1'b0;
    if (ack) e_rdy = 1'b0;
    model_byte(b);
  endtask

  task automatic ack();
    u_if.clr_cmd_rdy = 1'b1;
    tick();
    u_if.clr_cmd_rdy = 1'b0;
    e_rdy = 1'b0;
  endtask

  task automatic check_rx(input string tag);
    settle();
    chk({tag, "_cmd"}, u_if.cmd, e_cmd);
    chk({tag, "_cmd_rdy"}, u_if.cmd_rdy, e_rdy);
    chk({tag, "_frame_err_count"}, n_ferr, e_ferr);
    chk({tag, "_cmd_ovr_count"}, n_ovr, e_ovr);
    chk({tag, "_clr_rx_rdy_count"}, n_clr, e_clr);
  endtask

  task automatic do_reset();
    settle();
    rst = 1'b1;
    u_if.rx_rdy = 1'b0;
    u_if.clr_cmd_rdy = 1'b0;
    u_if.send_resp = 1'b0;
    u_if.tx_done = 1'b1;
    u_cnt = 0;
    idle(2);
    rst = 1'b0;
    have_hi = 0;
    e_cmd = '0;
    e_rdy = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd"}, u_if.cmd, 0);
    chk({tag, "_cmd_rdy"}, u_if.cmd_rdy, 0);
    chk({tag, "_tx_data"}, u_if.tx_data, 0);
    chk({tag, "_resp_busy"}, u_if.resp_busy, 0);
    chk({tag, "_trmt"}, u_if.trmt, 0);
    chk({tag, "_frame_err"}, u_if.frame_err, 0);
    chk({tag, "_cmd_ovr"}, u_if.cmd_ovr, 0);
    chk({tag, "_resp_sent"}, u_if.resp_sent, 0);
    chk({tag, "_clr_rx_rdy"}, u_if.clr_rx_rdy, 0);
  endtask

  task automatic resp_txn(input logic [7:0] r, input bit inject);
    int k, t0, s0;
    bit busy_ok;
    t0 = n_trmt;
    s0 = n_sent;
    busy_ok = 1;
    k = 0;
    u_if.resp = r;
    u_if.send_resp = 1'b1;
    tick();
    u_if.send_resp = 1'b0;
    chk("resp_busy_set", u_if.resp_busy, 1);
    while (!u_if.resp_sent && k < 400) begin
      if (!u_if.resp_busy) busy_ok = 0;
      if (inject && k == 20) begin
        u_if.resp = ~r;
        u_if.send_resp = 1'b1;
        tick();
        u_if.send_resp = 1'b0;
      end else tick();
      k++;
    end
    chk("resp_sent_seen", u_if.resp_sent, 1);
    chk("resp_trmt_count", n_trmt - t0, 1);
    chk("resp_trmt_data", trmt_data, r);
    chk("resp_tx_data_hold", u_if.tx_data, r);
    chk("resp_busy_held", busy_ok, 1);
    chk("resp_busy_clear", u_if.resp_busy, 0);
    tick();
    chk("resp_sent_pulse", n_sent - s0, 1);
    chk("resp_sent_low", u_if.resp_sent, 0);
  endtask

  initial begin
    u_if.rx_rdy = 1'b0;
    u_if.rx_data = '0;
    u_if.tx_done = 1'b1;
    u_if.clr_cmd_rdy = 1'b0;
    u_if.send_resp = 1'b0;
    u_if.resp = '0;
    do_reset();
    check_zero("reset");
    send_byte(8'hA5, 0);
    chk("frame_hi_no_rdy", u_if.cmd_rdy, 0);
    send_byte(8'h3C, 0);
    chk("frame_cmd_A53C", u_if.cmd, 16'hA53C);
    check_rx("frame");
    ack();
    check_rx("frame_ack");
    send_byte(8'h12, 0);
    idle(T - 1);
    chk("timeout_early", n_ferr, e_ferr);
    tick();
    chk("timeout_pulse", u_if.frame_err, 1);
    check_rx("timeout");
    idle(3);
    check_rx("timeout_after");
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    chk("resync_cmd", u_if.cmd, 16'h5678);
    check_rx("resync");
    ack();
    send_byte(8'h21, 0);
    idle(T - 2);
    send_byte(8'h43, 0);
    chk("boundary_cmd", u_if.cmd, 16'h2143);
    check_rx("boundary");
    ack();
    send_byte(8'h65, 0);
    idle(T - 1);
    send_byte(8'h87, 0);
    check_rx("priority");
    ack();
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h22, 0);
    chk("ovr_pulse", u_if.cmd_ovr, 1);
    chk("ovr_cmd", u_if.cmd, 16'h2222);
    tick();
    chk("ovr_pulse_end", u_if.cmd_ovr, 0);
    check_rx("ovr");
    ack();
    send_byte(8'h33, 0);
    send_byte(8'h44, 1);
    chk("set_wins", u_if.cmd_rdy, 1);
    check_rx("simul");
    ack();
    resp_txn(8'hC3, 1);
    send_byte(8'h77, 0);
    u_if.resp = 8'h5A;
    u_if.send_resp = 1'b1;
    tick();
    u_if.send_resp = 1'b0;
    idle(5);
    do_reset();
    check_zero("midreset");
    idle(3);
    chk("midreset_no_trmt", u_if.trmt, 0);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 0);
    chk("after_reset_cmd", u_if.cmd, 16'h9ABC);
    check_rx("after_reset");
    ack();
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        idle($urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(T - 3, T + 2));
        send_byte(8'($urandom_range(0, 255)), 0);
      end else if (op <= 7) ack();
      else if (op == 8) idle($urandom_range(1, 10));
      else resp_txn(8'($urandom_range(0, 255)), 0);
      check_rx("rand");
    end
    idle(T + 2);
    check_rx("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
